// File: rtl/ifm_stream_loader.sv
// IFM write-side loader: lands a valid/ready word stream linearly in the IFM dpram
// and publishes a rows-loaded count so row fetch can start before the frame completes.
module ifm_stream_loader #(
  parameter int W_SIZE    = 9,
  parameter int W_CHANNEL = 9,
  parameter int IFM_DW    = 32,
  parameter int IFM_DEPTH = 65536,
  parameter int IFM_AW    = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        q_load_ifm,
  input  logic [W_SIZE-1:0]           q_height,
  input  logic [W_SIZE+W_CHANNEL-1:0] q_row_stride,
  output logic                        o_busy,
  output logic                        o_load_ifm_done,
  output logic [W_SIZE-1:0]           o_rows_loaded,
  output logic                        o_err,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [IFM_DW-1:0]           s_tdata,
  input  logic                        s_tlast,
  output logic                        ifm_ena,
  output logic                        ifm_wea,
  output logic [IFM_AW-1:0]           ifm_addra,
  output logic [IFM_DW-1:0]           ifm_dia
);

  localparam int W_STRIDE = W_SIZE + W_CHANNEL;
  localparam int W_TOTAL  = W_STRIDE + W_SIZE;

  typedef enum logic [1:0] {IDLE, SIZE, LOAD, DONE} state_t;

  state_t              r_state;
  logic [W_SIZE-1:0]   r_height;
  logic [W_STRIDE-1:0] r_stride;
  logic [W_STRIDE-1:0] r_col_cnt;
  logic [W_TOTAL-1:0]  r_total;
  logic [W_TOTAL-1:0]  r_word_cnt;
  logic [W_SIZE-1:0]   r_rows;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_tready;

  logic [W_TOTAL-1:0]  w_total;
  logic                w_hs;
  logic                w_last_word;
  logic                w_row_end;

  assign w_total     = W_TOTAL'(r_stride) * W_TOTAL'(r_height);
  assign w_hs        = s_tvalid & r_tready;
  assign w_last_word = (r_word_cnt == r_total - W_TOTAL'(1));
  assign w_row_end   = (r_col_cnt == r_stride - W_STRIDE'(1));

  assign o_busy          = r_busy;
  assign o_load_ifm_done = r_done;
  assign o_rows_loaded   = r_rows;
  assign o_err           = r_err;
  assign s_tready        = r_tready;
  assign ifm_ena         = w_hs;
  assign ifm_wea         = w_hs;
  assign ifm_addra       = r_word_cnt[IFM_AW-1:0];
  assign ifm_dia         = s_tdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_height   <= '0;
      r_stride   <= '0;
      r_col_cnt  <= '0;
      r_total    <= '0;
      r_word_cnt <= '0;
      r_rows     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tready   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (q_load_ifm) begin
            r_height   <= q_height;
            r_stride   <= q_row_stride;
            r_err      <= 1'b0;
            r_rows     <= '0;
            r_word_cnt <= '0;
            r_col_cnt  <= '0;
            r_busy     <= 1'b1;
            r_state    <= SIZE;
          end
        end
        SIZE: begin
          r_total <= w_total;
          if (w_total == '0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_total > W_TOTAL'(IFM_DEPTH)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_tready <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_word_cnt <= r_word_cnt + W_TOTAL'(1);
            if (w_row_end) begin
              r_col_cnt <= '0;
              r_rows    <= r_rows + W_SIZE'(1);
            end else begin
              r_col_cnt <= r_col_cnt + W_STRIDE'(1);
            end
            // TLAST must coincide exactly with the final word; an early one is flagged but not fatal
            if (s_tlast != w_last_word) r_err <= 1'b1;
            if (w_last_word) begin
              r_tready <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_stream_loader.sv
// Directed bench for ifm_stream_loader: small frames, gaps, empty/oversize frames,
// TLAST mismatch with ignored restart, and reset mid-frame.
module tb_ifm_stream_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        q_load_ifm = 1'b0;
  logic [8:0]  q_height = '0;
  logic [17:0] q_row_stride = '0;
  logic        o_busy, o_load_ifm_done, o_err;
  logic [8:0]  o_rows_loaded;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        ifm_ena, ifm_wea;
  logic [15:0] ifm_addra;
  logic [31:0] ifm_dia;

  int tests = 0;
  int fails = 0;

  ifm_stream_loader #(.W_SIZE(9), .W_CHANNEL(9), .IFM_DW(32), .IFM_DEPTH(65536), .IFM_AW(16)) dut (
    .clk(clk), .rstn(rstn), .q_load_ifm(q_load_ifm), .q_height(q_height),
    .q_row_stride(q_row_stride), .o_busy(o_busy), .o_load_ifm_done(o_load_ifm_done),
    .o_rows_loaded(o_rows_loaded), .o_err(o_err), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .ifm_ena(ifm_ena), .ifm_wea(ifm_wea),
    .ifm_addra(ifm_addra), .ifm_dia(ifm_dia)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write/done monitor, sampled on the falling edge where everything is settled
  logic [31:0] mem [0:63];
  int          rows_after [0:63];
  int          wr_cnt, done_cnt, done_cyc, last_wr_cyc;
  bit          ready_seen, prev_wr;
  logic [5:0]  prev_addr;

  always @(negedge clk) begin
    if (prev_wr) rows_after[prev_addr] = int'(o_rows_loaded);
    prev_wr   = ifm_ena && ifm_wea;
    prev_addr = ifm_addra[5:0];
    if (prev_wr) begin
      mem[prev_addr] = ifm_dia;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (o_load_ifm_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_tready) ready_seen = 1'b1;
  end

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; ready_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hDEAD_BEEF;
      rows_after[i] = -1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int h, input int stride, output int st);
    q_load_ifm = 1'b1; q_height = 9'(h); q_row_stride = 18'(stride);
    st = cyc;
    @(posedge clk); #1;
    q_load_ifm = 1'b0;
  endtask

  task automatic stream(input int n, input int last_idx, input bit gaps,
                        input logic [31:0] base, input int inject_at);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    bit  hs;
    while (i < n && guard < 100) begin
      s_tvalid   = gaps ? ~ph : 1'b1;
      s_tdata    = base + 32'(i);
      s_tlast    = (i == last_idx);
      q_load_ifm = (i == inject_at);
      q_height   = 9'd5; q_row_stride = 18'd7;
      ph = ~ph;
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      q_load_ifm = 1'b0;
      if (hs) i++;
      guard++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tests++;
    if (i !== n) begin
      fails++;
      $display("FAIL stream_timeout: accepted %0d words, required %0d", i, n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b1;
    idle(2);
    @(negedge clk);
    tests++;
    if ({o_busy, o_load_ifm_done, o_err, s_tready, ifm_ena, ifm_wea} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b, required 000000",
                        {o_busy, o_load_ifm_done, o_err, s_tready, ifm_ena, ifm_wea});
    end
    tests++;
    if (o_rows_loaded !== 9'd0 || ifm_addra !== 16'd0) begin
      fails++; $display("FAIL reset_counts: rows %0d addr %0d, required 0 0", o_rows_loaded, ifm_addra);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_frame(input bit gaps);
    int st;
    clear_mon();
    start(2, 4, st);
    stream(8, 7, gaps, 32'hA500_0000, -1);
    idle(3);
    for (int a = 0; a < 8; a++) begin
      tests++;
      if (mem[a] !== 32'hA500_0000 + 32'(a)) begin
        fails++; $display("FAIL frame_data(gaps=%0d) addr %0d: got %h, required %h",
                          gaps, a, mem[a], 32'hA500_0000 + 32'(a));
      end
    end
    tests++;
    if (wr_cnt !== 8) begin fails++; $display("FAIL frame_writes: got %0d, required 8", wr_cnt); end
    tests++;
    if (rows_after[2] !== 0 || rows_after[3] !== 1 || rows_after[6] !== 1 || rows_after[7] !== 2) begin
      fails++; $display("FAIL frame_rows: after w2/w3/w6/w7 got %0d/%0d/%0d/%0d, required 0/1/1/2",
                        rows_after[2], rows_after[3], rows_after[6], rows_after[7]);
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== last_wr_cyc + 1) begin
      fails++; $display("FAIL frame_done: pulses %0d at cyc %0d, required 1 at cyc %0d",
                        done_cnt, done_cyc, last_wr_cyc + 1);
    end
    tests++;
    if (o_err !== 1'b0 || o_busy !== 1'b0 || o_rows_loaded !== 9'd2) begin
      fails++; $display("FAIL frame_end: err %b busy %b rows %0d, required 0 0 2", o_err, o_busy, o_rows_loaded);
    end
  endtask

  task automatic test_empty();
    int st;
    clear_mon();
    s_tvalid = 1'b1; s_tlast = 1'b1;
    start(0, 4, st);
    idle(4);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tests++;
    if (wr_cnt !== 0 || ready_seen !== 1'b0) begin
      fails++; $display("FAIL empty_nowrite: writes %0d ready_seen %b, required 0 0", wr_cnt, ready_seen);
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== st + 2) begin
      fails++; $display("FAIL empty_done: pulses %0d at cyc %0d, required 1 at cyc %0d", done_cnt, done_cyc, st + 2);
    end
    tests++;
    if (o_err !== 1'b0) begin fails++; $display("FAIL empty_err: got %b, required 0", o_err); end
  endtask

  task automatic test_oversize();
    int st;
    clear_mon();
    s_tvalid = 1'b1;
    start(129, 512, st);
    idle(4);
    s_tvalid = 1'b0;
    tests++;
    if (wr_cnt !== 0 || ready_seen !== 1'b0 || done_cnt !== 1) begin
      fails++; $display("FAIL oversize_flow: writes %0d ready %b done %0d, required 0 0 1",
                        wr_cnt, ready_seen, done_cnt);
    end
    tests++;
    if (o_err !== 1'b1) begin fails++; $display("FAIL oversize_err: got %b, required 1", o_err); end
    start(1, 2, st);
    @(negedge clk);
    tests++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      fails++; $display("FAIL restart_clear: err %b busy %b, required 0 1", o_err, o_busy);
    end
    @(posedge clk); #1;
    stream(2, 1, 1'b0, 32'h0000_0B00, -1);
    idle(3);
  endtask

  task automatic test_tlast_restart();
    int st;
    clear_mon();
    start(1, 3, st);
    stream(3, 1, 1'b0, 32'h5500_0010, 1);
    idle(6);
    tests++;
    if (wr_cnt !== 3 || mem[0] !== 32'h5500_0010 || mem[2] !== 32'h5500_0012) begin
      fails++; $display("FAIL tlast_writes: count %0d w0 %h w2 %h, required 3 55000010 55000012",
                        wr_cnt, mem[0], mem[2]);
    end
    tests++;
    if (o_err !== 1'b1) begin fails++; $display("FAIL tlast_err: got %b, required 1", o_err); end
    tests++;
    if (done_cnt !== 1 || done_cyc !== last_wr_cyc + 1 || o_busy !== 1'b0 || o_rows_loaded !== 9'd1) begin
      fails++; $display("FAIL tlast_done: pulses %0d cyc %0d(want %0d) busy %b rows %0d, required 1 - 0 1",
                        done_cnt, done_cyc, last_wr_cyc + 1, o_busy, o_rows_loaded);
    end
  endtask

  task automatic test_reset_midframe();
    int st;
    clear_mon();
    start(2, 4, st);
    stream(3, -1, 1'b0, 32'h7700_0000, -1);
    s_tvalid = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    tests++;
    if ({o_busy, s_tready, ifm_ena, o_load_ifm_done} !== 4'b0 || o_rows_loaded !== 9'd0 || ifm_addra !== 16'd0) begin
      fails++; $display("FAIL midreset_out: busy/rdy/ena/done %b rows %0d addr %0d, required 0000 0 0",
                        {o_busy, s_tready, ifm_ena, o_load_ifm_done}, o_rows_loaded, ifm_addra);
    end
    @(posedge clk); #1;
    rstn = 1'b1; s_tvalid = 1'b0;
    idle(4);
    tests++;
    if (done_cnt !== 0 || wr_cnt !== 3) begin
      fails++; $display("FAIL midreset_nodone: done %0d writes %0d, required 0 3", done_cnt, wr_cnt);
    end
    clear_mon();
    start(2, 4, st);
    stream(8, 7, 1'b0, 32'hC300_0000, -1);
    idle(3);
    tests++;
    if (wr_cnt !== 8 || mem[0] !== 32'hC300_0000 || mem[7] !== 32'hC300_0007 || done_cnt !== 1) begin
      fails++; $display("FAIL midreset_reload: writes %0d w0 %h w7 %h done %0d, required 8 c3000000 c3000007 1",
                        wr_cnt, mem[0], mem[7], done_cnt);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_empty();
    test_oversize();
    test_tlast_restart();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
